// File: rtl/ws2812_frame.sv
// ws2812_frame: pixel frame buffer and sequencer ahead of the WS2812 transmitter.
// Streams every stored pixel as a GRB word over start/bsy, then holds the latch gap.
module ws2812_frame #(
    parameter real F_CLK  = 48e6,
    parameter int  N_LEDS = 8,
    parameter int  N_RES  = 3840,
    localparam int AW = $clog2(N_LEDS),
    localparam int CW = $clog2(N_RES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          show,
    output logic [23:0]   tx_data,
    output logic          tx_start,
    input  logic          tx_bsy,
    output logic          busy,
    output logic          frame_done
);

    if (N_LEDS < 2 || F_CLK <= 0.0) begin : g_param_check
        $error("ws2812_frame: N_LEDS must be >= 2 and F_CLK positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        LATCH
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N_LEDS - 1);
    localparam logic [CW-1:0] LTC  = CW'(N_RES - 1);

    state_t        state, state_n;
    logic          pending, pending_n;
    logic [AW-1:0] addr, addr_n;
    logic [CW-1:0] lcnt, lcnt_n;
    logic          done_n;

    logic [23:0] mem [N_LEDS];
    logic [23:0] rd;

    // Buffer has no reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < N_LEDS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd = mem[addr];

    always_comb begin
        state_n   = state;
        pending_n = pending;
        addr_n    = addr;
        lcnt_n    = lcnt;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (show || pending) begin
                    pending_n = 1'b0;
                    addr_n    = '0;
                    state_n   = LOAD;
                end
            end
            LOAD:    state_n = START;
            START:   state_n = WAIT_HI;
            WAIT_HI: begin
                if (tx_bsy) state_n = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_bsy) begin
                    if (addr == LAST) begin
                        lcnt_n  = '0;
                        state_n = LATCH;
                    end else begin
                        addr_n  = addr + 1'b1;
                        state_n = LOAD;
                    end
                end
            end
            LATCH: begin
                if (lcnt == LTC) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // At most one frame queued behind the active one.
        if (state != IDLE && show) pending_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            addr       <= '0;
            lcnt       <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            addr       <= addr_n;
            lcnt       <= lcnt_n;
            tx_start   <= (state_n == START);
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
            if (state == LOAD) begin
                tx_data <= {rd[15:8], rd[23:16], rd[7:0]};
            end
        end
    end

endmodule

// File: tb/tb_ws2812_frame.sv
// tb_ws2812_frame: scoreboard bench for ws2812_frame with a 5-cycle bsy model.
// Expected GRB words are queued at show time and popped on every tx_start.
module tb_ws2812_frame;

    localparam int N  = 3;
    localparam int NR = 10;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          show;
    logic [23:0]   tx_data;
    logic          tx_start;
    logic          tx_bsy;
    logic          busy;
    logic          frame_done;

    ws2812_frame #(.F_CLK(48e6), .N_LEDS(N), .N_RES(NR)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .show(show), .tx_data(tx_data),
        .tx_start(tx_start), .tx_bsy(tx_bsy), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: bsy rises the cycle after start, holds 5 cycles.
    int bcnt;
    always @(posedge clk) begin
        if (rst) begin
            tx_bsy <= 1'b0;
            bcnt   <= 0;
        end else if (tx_start) begin
            tx_bsy <= 1'b1;
            bcnt   <= 5;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_bsy <= 1'b0;
        end
    end

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain buffer plus the RGB->GRB rule.
    logic [23:0] model [N];
    logic [23:0] sb [$];

    function automatic logic [23:0] grb(input logic [23:0] p);
        return {p[15:8], p[23:16], p[7:0]};
    endfunction

    function automatic void push_frame();
        for (int i = 0; i < N; i++) sb.push_back(grb(model[i]));
    endfunction

    // Monitor
    int   ndone = 0;
    int   nword = 0;
    int   gap   = 0;
    logic bsy_prev   = 1'b0;
    logic start_prev = 1'b0;
    logic hold_v     = 1'b0;
    logic [23:0] held;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (tx_start) begin
                if (start_prev) chk("start_width", 32'(start_prev), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_start", 32'(tx_data), 32'hFFFFFFFF);
                end else begin
                    chk("word", 32'(tx_data), 32'(sb.pop_front()));
                end
                nword++;
                held   = tx_data;
                hold_v = 1'b1;
                gap    = -1000;
            end
            if (tx_bsy && hold_v) chk("stable", 32'(tx_data), 32'(held));
            if (bsy_prev && !tx_bsy) gap = 0;
            else gap++;
            if (frame_done) begin
                ndone++;
                chk("latch_gap", 32'(gap), 32'(NR + 1));
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        bsy_prev   = tx_bsy;
        start_prev = tx_start;
    end

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (a < N) model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_show();
        @(negedge clk);
        show = 1'b1;
        @(negedge clk);
        show = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k;
        k = 0;
        while (ndone <= n0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (ndone <= n0) chk("done_timeout", 32'(k), 0);
    endtask

    task automatic wait_word(input int target);
        int k;
        k = 0;
        while (!(nword >= target && tx_bsy) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("word_timeout", 32'(nword), 32'(target));
    endtask

    int n0, w0;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; show = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        // Directed frame
        wr(0, 24'h112233);
        wr(1, 24'h445566);
        wr(2, 24'h778899);
        push_frame();
        n0 = ndone;
        pulse_show();
        wait_done(n0);

        // Queued show during pixel 1, a third show merged
        n0 = ndone;
        w0 = nword;
        push_frame();
        pulse_show();
        wait_word(w0 + 2);
        push_frame();
        pulse_show();
        repeat (3) @(negedge clk);
        pulse_show();
        wait_done(n0);
        @(negedge clk);
        chk("requeue_busy", 32'(busy), 1);
        wait_done(n0 + 1);
        repeat (30) @(negedge clk);
        chk("merged_frames", 32'(ndone - n0), 2);
        chk("merged_sb_empty", 32'(sb.size()), 0);

        // Mid-frame write of a pixel not yet loaded, and an ignored address
        n0 = ndone;
        w0 = nword;
        sb.push_back(grb(model[0]));
        sb.push_back(grb(model[1]));
        pulse_show();
        wait_word(w0 + 1);
        wr(2, 24'hFF0000);
        wr(3, 24'h123456);
        sb.push_back(24'h00FF00);
        wait_done(n0);
        n0 = ndone;
        push_frame();
        pulse_show();
        wait_done(n0);

        // Reset during pixel 1
        n0 = ndone;
        w0 = nword;
        sb.push_back(grb(model[0]));
        sb.push_back(grb(model[1]));
        pulse_show();
        wait_word(w0 + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_start", 32'(tx_start), 0);
        repeat (30) @(negedge clk);
        chk("rst_mid_no_done", 32'(ndone), 32'(n0));
        chk("rst_mid_sb", 32'(sb.size()), 0);
        push_frame();
        pulse_show();
        wait_done(n0);

        // Randomized buffer contents
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = $urandom_range(1, 5);
            for (int j = 0; j < nw; j++) begin
                wr($urandom_range(0, 3), 24'($urandom));
            end
            n0 = ndone;
            push_frame();
            pulse_show();
            wait_done(n0);
        end

        repeat (20) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 0);
        chk("final_idle", 32'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ws2812_frame.md
Name: ws2812_frame

Overview:
- Upstream stage of the WS2812 serial transmitter.
- Holds a frame buffer of N_LEDS pixels written by the host in RGB order.
- On a show request it streams every pixel, reordered to GRB, to the transmitter one 24-bit word at a time using the transmitter's start/bsy handshake.
- After the last pixel it holds the line idle for the reset/latch period, then reports the frame as done.

Parameters:
- F_CLK, 48e6, clock frequency in Hz; documentation only, must match the transmitter.
- N_LEDS, 8, number of pixels in the strip; must be 2 or more.
- N_RES, 3840, latch cycles with the line low after the last pixel (80 us at 48 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  frame buffer write strobe.
- wr_addr  in  AW = $clog2(N_LEDS)  pixel index to write.
- wr_data  in  24  pixel colour as {R[7:0], G[7:0], B[7:0]}.
- show  in  1  request to transmit the whole frame; level or pulse.
- tx_data  out  24  word to the transmitter as {G, R, B}, MSB first on the wire.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_bsy  in  1  transmitter busy flag.
- busy  out  1  high from frame acceptance until DONE.
- frame_done  out  1  one-cycle pulse when the latch period ends.

Behaviour:
- Reset values:
  - outputs: tx_data = 0, tx_start = 0, busy = 0, frame_done = 0;
  - internal: state = IDLE, pending = 0, address and latch counters = 0.
  - Buffer contents are not reset.
- Buffer:
  - N_LEDS x 24 synchronous RAM with 1-cycle read latency; inference as iCE40 BRAM or registers is permitted.
  - A write with wr_en = 1 and wr_addr < N_LEDS lands on the clock edge.
  - wr_addr >= N_LEDS is ignored.
  - Writes are accepted in every state. A pixel carries its value as of its LOAD read cycle.
  - A write and a read to the same address in the same cycle returns the old data.
- Colour reorder: tx_data = {rd[15:8], rd[23:16], rd[7:0]}.
- FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO, LATCH.
  - IDLE: if show or pending, then clear pending, set addr = 0, set busy = 1, go to LOAD.
  - LOAD: issue the read of addr. Next cycle register tx_data from the reordered read data, go to START.
  - START: assert tx_start for exactly 1 cycle, go to WAIT_HI.
  - WAIT_HI: wait for tx_bsy = 1, then go to WAIT_LO. The transmitter raises bsy the cycle after start.
  - WAIT_LO: wait for tx_bsy = 0.
    - If addr == N_LEDS-1: clear the latch counter, go to LATCH.
    - Otherwise: addr = addr + 1, go to LOAD.
  - LATCH: count N_RES cycles with no tx_start. On terminal count, pulse frame_done, set busy = 0, go to IDLE.
- tx_data rules:
  - tx_data is stable from START until tx_bsy falls. The transmitter samples data bit-by-bit throughout the word.
  - tx_data changes only on the LOAD→START transition.
- Pixel gap: the inter-pixel gap adds 3 cycles of low line beyond the transmitter's own bit-low time, which is within WS2812 tolerance.
- Show requests:
  - show while busy = 1 sets pending. At most one frame is queued; further requests while pending is set are merged.
  - A show in the same cycle as the LATCH terminal count sets pending, so the next frame starts 1 cycle after frame_done.
  - A level-held show retransmits back-to-back frames, each separated by the full latch period.
- Counters:
  - addr is AW bits.
  - Latch counter is $clog2(N_RES+1) bits and never wraps.
- Reset mid-operation: synchronous return to IDLE on the next edge. tx_start is low on that edge and pending is cleared. The transmitter is reset by the same rst net.
- No timeout on tx_bsy. A transmitter that never drops bsy stalls the block, by design.

Test Plan:
- Bench setup: N_LEDS = 3, N_RES = 10, a real transmitter or a bsy model holding bsy 5 cycles.
- Write {R,G,B} = 24'h112233, 24'h445566, 24'h778899 to addr 0..2, pulse show → tx_data sequence 24'h221133, 24'h554466, 24'h887799. Each word has exactly one tx_start, and tx_data is constant while tx_bsy = 1.
- After the 3rd tx_bsy fall → no tx_start for 10 cycles, then frame_done pulses 1 cycle and busy drops in the same cycle.
- show pulsed mid-frame (during the 2nd pixel) → the current frame completes, then a second frame starts 1 cycle after frame_done. A third show during the same frame does not add a further frame.
- During the 1st pixel's WAIT_LO, write addr 2 = 24'hFF0000 → the 3rd word sent is 24'h00FF00. Write to addr 3 → no effect on any buffer entry.
- Assert rst for 1 cycle while in WAIT_LO of pixel 1 → busy = 0, tx_start = 0 next cycle, no frame_done. A subsequent show sends from pixel 0.
